uart_tx_fifo_param: RTL

//  Parametrised UART transmitter: next generation of the fixed 8N1 transmitter.

---
 rtl/uart_tx_fifo_param_pkg.sv | 23 ++
 rtl/uart_tx_fifo_param_fifo.sv | 48 ++++
 rtl/uart_tx_fifo_param.sv | 133 +++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_param_pkg.sv
// uart_tx_fifo_param_pkg: shared FSM encodings, parity codes, line levels and parity helper
// Contents:
//   S_*        3-bit FSM state encodings (IDLE=0 .. STOP=4)
//   PAR_*      parity mode codes (NONE=0, ODD=1, EVEN=2)
//   START_BIT  line level of the start bit
//   STOP_BIT   line level of stop bits and of the idle line
//   parity_bit level sent in the parity slot for a given mode and word
package uart_tx_fifo_param_pkg;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    // Zero-extended bits do not change the XOR, so any word width up to 9 fits.
    function automatic logic parity_bit(input logic [1:0] mode, input logic [8:0] data);
        return (mode == PAR_EVEN) ? ^data : ~^data;
    endfunction
endpackage

// File: rtl/uart_tx_fifo_param_fifo.sv
// uart_fifo: synchronous FIFO with first-word read (o_dout shows the head word while not empty)
// Ports:
//   i_clock, i_reset  clock, asynchronous active-high reset (empties the FIFO)
//   i_push, i_din     enqueue i_din; ignored when full unless a pop happens in the same cycle
//   i_pop             dequeue the head word; ignored when empty
//   o_dout            head word
//   o_full, o_empty   occupancy flags
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_dout  = r_mem[r_rd];
    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    always_ff @(posedge i_clock) begin
        if (w_push) r_mem[r_wr] <= i_din;
    end
    // Pointers are exactly log2(DEPTH) bits wide, so they wrap without compare logic.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/uart_tx_fifo_param.sv
// uart_tx_fifo_param: parametrised UART transmitter with a write FIFO for back-to-back frames
// Ports:
//   i_clock     system clock
//   i_reset     asynchronous active-high reset; abandons any frame, line returns to idle
//   i_s_tick    baud-generator pulse, OVERSAMPLE pulses per bit period
//   i_wr_en     write request, one word per cycle
//   i_data_in   word to enqueue (sent LSB first)
//   o_full      FIFO holds FIFO_DEPTH words
//   o_overflow  sticky flag: a write was dropped
//   o_tx        registered serial line, idle high
//   o_tx_busy   a frame is in progress
//   o_tx_done   one-cycle pulse when the last stop bit completes
module uart_tx_fifo_param
    import uart_tx_fifo_param_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_s_tick,
    input  logic                 i_wr_en,
    input  logic [DATA_BITS-1:0] i_data_in,
    output logic                 o_full,
    output logic                 o_overflow,
    output logic                 o_tx,
    output logic                 o_tx_busy,
    output logic                 o_tx_done
);
    localparam int TW = $clog2(2*OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS+1);
    localparam logic [TW-1:0] BIT_END  = TW'(OVERSAMPLE-1);
    localparam logic [TW-1:0] STOP_END = TW'(STOP_BITS*OVERSAMPLE-1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS-1);
    logic [2:0]           r_state;
    logic [TW-1:0]        r_tick;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_ovf;
    logic [DATA_BITS-1:0] w_dout;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_bit_end;
    logic                 w_stop_end;
    logic                 w_pop;
    logic                 w_push;
    assign w_bit_end  = i_s_tick && r_tick == BIT_END;
    assign w_stop_end = i_s_tick && r_tick == STOP_END;
    // Popping at the end of STOP chains the next frame with no idle bit in between.
    assign w_pop  = !w_empty && (r_state == S_IDLE || (r_state == S_STOP && w_stop_end));
    assign w_push = i_wr_en && (!w_full || w_pop);
    assign o_full     = w_full;
    assign o_overflow = r_ovf;
    assign o_tx       = r_tx;
    assign o_tx_busy  = r_busy;
    assign o_tx_done  = r_done;
    uart_fifo #(
        .WIDTH(DATA_BITS),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .i_clock(i_clock),
        .i_reset(i_reset),
        .i_push (w_push),
        .i_pop  (w_pop),
        .i_din  (i_data_in),
        .o_dout (w_dout),
        .o_full (w_full),
        .o_empty(w_empty)
    );
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= STOP_BIT;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_wr_en && !w_push) r_ovf <= 1'b1;
            // STOP spans STOP_BITS bit periods, so only its own end wraps the tick counter.
            if (i_s_tick && r_state != S_IDLE)
                r_tick <= ((w_bit_end && r_state != S_STOP) || w_stop_end) ? '0 : r_tick + 1'b1;
            case (r_state)
                S_IDLE: ;
                S_START: if (w_bit_end) begin
                    r_state <= S_DATA;
                    r_tx    <= r_shift[0];
                end
                S_DATA: if (w_bit_end) begin
                    if (r_bit == LAST_BIT) begin
                        r_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        r_tx    <= (PARITY != 0) ? r_par : STOP_BIT;
                    end else begin
                        r_bit   <= r_bit + 1'b1;
                        r_shift <= r_shift >> 1;
                        r_tx    <= r_shift[1];
                    end
                end
                S_PARITY: if (w_bit_end) begin
                    r_state <= S_STOP;
                    r_tx    <= STOP_BIT;
                end
                S_STOP: if (w_stop_end) begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
            // Parity is computed from the word as popped, so later shifting cannot affect it.
            if (w_pop) begin
                r_state <= S_START;
                r_shift <= w_dout;
                r_par   <= parity_bit(2'(PARITY), 9'(w_dout));
                r_tx    <= START_BIT;
                r_busy  <= 1'b1;
                r_tick  <= '0;
                r_bit   <= '0;
            end
        end
    end
endmodule
